div_result_bcd: RTL
===================

// Module: div_result_bcd
// PURPOSE
//  Downstream stage of the 8-bit unsigned divider. Accepts one quotient/remainder/overflow
//  triple per transaction and converts q and r to packed BCD using iterative double-dabble
//  (both converted in parallel). The results drive the decimal display/readout path.
//  Valid/ready on both sides; one conversion in flight at a time.
// PARAMETERS
//  W   8   binary width of quotient and remainder
//  ND  3   BCD digits per result; must satisfy 10**ND > 2**W - 1
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      divider result presented
//  in_ready   out  1      stage can accept (high only in IDLE)
//  in_q       in   W      quotient from divider
//  in_r       in   W      remainder from divider
//  in_ovf     in   1      divider overflow / divide-by-zero flag
//  out_valid  out  1      converted result available
//  out_ready  in   1      consumer accepts result
//  out_q_bcd  out  4*ND   quotient, packed BCD, digit 0 in bits [3:0]
//  out_r_bcd  out  4*ND   remainder, packed BCD
//  out_ovf    out  1      overflow flag carried with result
//  busy       out  1      high in SHIFT or DONE
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, out_valid=0, out_q_bcd=out_r_bcd=0, out_ovf=0, shift cnt=0.
//   Reset beats every other event; reset mid-SHIFT/DONE aborts, and no result is emitted.
//  FSM IDLE -> SHIFT -> DONE -> IDLE:
//   IDLE : in_ready=1. On in_valid&&in_ready, capture q, r, ovf. Then:
//          ovf=0 -> clear BCD accumulators, cnt=W, go SHIFT.
//          ovf=1 -> load both BCD outputs with all-ones (BCD_INVALID, 12'hFFF), out_ovf=1, go DONE.
//   SHIFT: each edge, for each of q and r: every digit >=5 gets +3, then {bcd,src} shifts left by 1.
//          cnt decrements. When cnt reaches 1 at an edge, take the final shift and go DONE.
//   DONE : out_valid=1; outputs held stable while out_ready=0. On out_valid&&out_ready go IDLE.
//  Latency: acceptance edge E -> out_valid visible after edge E+W (8); ovf path: after edge E+1.
//  Throughput with out_ready=1: one accept every W+2 edges (10). There is no accept in the same
//   cycle as output handshake; in_ready rises the cycle after handshake.
//  Inputs are sampled only at acceptance. Input changes and in_valid pulses while busy are ignored.
//  out_q_bcd/out_r_bcd/out_ovf update only when entering DONE and hold through the next IDLE.
//  All arithmetic is unsigned. Digit add-3 is a 4-bit add with no carry out (digit <=9 guaranteed).
// STRUCTURE
//  Shared header div_defs.vh: W/ND defaults, state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2),
//   BCD_INVALID constant. The divider bench also includes this header.
//  Sub-module bcd_dabble_step (combinational: in bcd[4*ND], src[W] -> out bcd, src after one
//   add-3+shift), instantiated twice (q and r). FSM, counter, and regs live in top.
//  Counter width clog2(W+1). There are no latches or combinational paths from in_* to out_*.
// TESTING
//  1 Reset held 2 cycles, then idle -> in_ready=1, out_valid=0, all outputs 0, busy=0.
//  2 q=255 r=0 ovf=0 -> exactly 8 cycles later out_q_bcd=12'h255, out_r_bcd=12'h000, out_ovf=0.
//  3 q=9 r=99, out_ready low 5 cycles -> outputs stable 12'h009/12'h099, in_ready=0; then
//    raise out_ready -> out_valid drops, in_ready=1 next cycle.
//  4 in_ovf=1 (b=0 at divider), any q/r -> out_valid after 1 cycle, both BCD=12'hFFF, out_ovf=1.
//  5 rst pulsed in 4th SHIFT cycle -> out_valid never rises, IDLE after reset; next q=100 r=7
//    -> 12'h100 / 12'h007.
//  6 in_valid and out_ready tied high, sweep all q,r in 0..255 -> one result per 10 cycles,
//    each matches a decimal reference model; in_valid pulses while busy are not accepted.

Source files
------------

// File: rtl/div_result_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module : div_result_bcd_pkg
// Brief  : Shared widths, FSM encoding and constants for the BCD result stage.
// Rev    : 1.0  initial release
// ============================================================================
package div_result_bcd_pkg;

    localparam int c_w  = 8;
    localparam int c_nd = 3;

    // Reported in both BCD fields when the divider flags overflow.
    localparam logic [4*c_nd-1:0] c_bcd_invalid = 12'hFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/div_result_bcd_if.sv
`default_nettype none
// ============================================================================
// Module : div_result_bcd_if
// Brief  : Input and output valid/ready channels of the BCD result stage.
// Rev    : 1.0  initial release
// ============================================================================
interface div_result_bcd_if
    import div_result_bcd_pkg::*;
#(
    parameter int W  = c_w,
    parameter int ND = c_nd
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_q;
    logic [W-1:0]    in_r;
    logic            in_ovf;
    logic            out_valid;
    logic            out_ready;
    logic [4*ND-1:0] out_q_bcd;
    logic [4*ND-1:0] out_r_bcd;
    logic            out_ovf;
    logic            busy;

    modport slave (
        input  in_valid, in_q, in_r, in_ovf, out_ready,
        output in_ready, out_valid, out_q_bcd, out_r_bcd, out_ovf, busy
    );

    modport master (
        output in_valid, in_q, in_r, in_ovf, out_ready,
        input  in_ready, out_valid, out_q_bcd, out_r_bcd, out_ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/bcd_dabble_step.sv
`default_nettype none
// ============================================================================
// Module : bcd_dabble_step
// Brief  : One double-dabble iteration: add-3 to digits >= 5, then shift left.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_dabble_step
    import div_result_bcd_pkg::*;
#(
    parameter int W  = c_w,
    parameter int ND = c_nd
) (
    input  wire logic [4*ND-1:0] i_bcd,
    input  wire logic [W-1:0]    i_src,
    output logic      [4*ND-1:0] o_bcd,
    output logic      [W-1:0]    o_src
);
    logic [4*ND-1:0] w_adj;

    for (genvar k = 0; k < ND; k++) begin : g_digit
        logic [3:0] w_digit;
        assign w_digit          = i_bcd[4*k +: 4];
        // Digits never exceed 9, so the 4-bit add cannot carry out.
        assign w_adj[4*k +: 4]  = (w_digit >= 4'd5) ? (w_digit + 4'd3) : w_digit;
    end

    assign {o_bcd, o_src} = {w_adj, i_src} << 1;

endmodule
`default_nettype wire

// File: rtl/div_result_bcd.sv
`default_nettype none
// ============================================================================
// Module : div_result_bcd
// Brief  : Converts divider quotient/remainder to packed BCD, one at a time.
// Rev    : 1.0  initial release
// ============================================================================
module div_result_bcd
    import div_result_bcd_pkg::*;
#(
    parameter int W  = c_w,
    parameter int ND = c_nd
) (
    input  wire logic         clk,
    input  wire logic         rst,
    div_result_bcd_if.slave   bus
);
    localparam int CW = $clog2(W + 1);

    state_e          r_state_q,     w_state_d;
    logic [CW-1:0]   r_cnt_q,       w_cnt_d;
    logic [W-1:0]    r_q_src_q,     w_q_src_d;
    logic [W-1:0]    r_r_src_q,     w_r_src_d;
    logic [4*ND-1:0] r_q_acc_q,     w_q_acc_d;
    logic [4*ND-1:0] r_r_acc_q,     w_r_acc_d;
    logic [4*ND-1:0] r_out_q_bcd_q, w_out_q_bcd_d;
    logic [4*ND-1:0] r_out_r_bcd_q, w_out_r_bcd_d;
    logic            r_out_ovf_q,   w_out_ovf_d;

    logic [4*ND-1:0] w_q_acc_step, w_r_acc_step;
    logic [W-1:0]    w_q_src_step, w_r_src_step;

    bcd_dabble_step #(.W(W), .ND(ND)) u_step_q (
        .i_bcd (r_q_acc_q),
        .i_src (r_q_src_q),
        .o_bcd (w_q_acc_step),
        .o_src (w_q_src_step)
    );

    bcd_dabble_step #(.W(W), .ND(ND)) u_step_r (
        .i_bcd (r_r_acc_q),
        .i_src (r_r_src_q),
        .o_bcd (w_r_acc_step),
        .o_src (w_r_src_step)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_q_src_d     = r_q_src_q;
        w_r_src_d     = r_r_src_q;
        w_q_acc_d     = r_q_acc_q;
        w_r_acc_d     = r_r_acc_q;
        w_out_q_bcd_d = r_out_q_bcd_q;
        w_out_r_bcd_d = r_out_r_bcd_q;
        w_out_ovf_d   = r_out_ovf_q;
        case (r_state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_ovf) begin
                        w_out_q_bcd_d = c_bcd_invalid;
                        w_out_r_bcd_d = c_bcd_invalid;
                        w_out_ovf_d   = 1'b1;
                        w_state_d     = S_DONE;
                    end else begin
                        w_q_src_d = bus.in_q;
                        w_r_src_d = bus.in_r;
                        w_q_acc_d = '0;
                        w_r_acc_d = '0;
                        w_cnt_d   = CW'(W);
                        w_state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                w_q_src_d = w_q_src_step;
                w_r_src_d = w_r_src_step;
                w_q_acc_d = w_q_acc_step;
                w_r_acc_d = w_r_acc_step;
                w_cnt_d   = r_cnt_q - CW'(1);
                // The last shift lands straight in the output registers.
                if (r_cnt_q == CW'(1)) begin
                    w_out_q_bcd_d = w_q_acc_step;
                    w_out_r_bcd_d = w_r_acc_step;
                    w_out_ovf_d   = 1'b0;
                    w_state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_cnt_q       <= '0;
            r_q_src_q     <= '0;
            r_r_src_q     <= '0;
            r_q_acc_q     <= '0;
            r_r_acc_q     <= '0;
            r_out_q_bcd_q <= '0;
            r_out_r_bcd_q <= '0;
            r_out_ovf_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_q_src_q     <= w_q_src_d;
            r_r_src_q     <= w_r_src_d;
            r_q_acc_q     <= w_q_acc_d;
            r_r_acc_q     <= w_r_acc_d;
            r_out_q_bcd_q <= w_out_q_bcd_d;
            r_out_r_bcd_q <= w_out_r_bcd_d;
            r_out_ovf_q   <= w_out_ovf_d;
        end
    end

    assign bus.in_ready  = (r_state_q == S_IDLE);
    assign bus.out_valid = (r_state_q == S_DONE);
    assign bus.busy      = (r_state_q == S_SHIFT) || (r_state_q == S_DONE);
    assign bus.out_q_bcd = r_out_q_bcd_q;
    assign bus.out_r_bcd = r_out_r_bcd_q;
    assign bus.out_ovf   = r_out_ovf_q;

endmodule
`default_nettype wire
